// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DMEM_ADDR_W   : default memory address width (32 locations)
//   DMEM_DATA_W   : default data width
//   DMEM_LOCK_MAX : default bound on consecutive locked grants under contention
//   owner_t       : lock ownership state of the arbiter
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W   = 5;
    localparam int DMEM_DATA_W   = 8;
    localparam int DMEM_LOCK_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   req, lock, we, addr, wdata : requester -> arbiter (held stable until gnt)
//   gnt                        : arbiter -> requester, access completes this cycle
//   rvalid, rdata              : arbiter -> requester, read data one cycle after gnt
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DMEM_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DMEM_DATA_W
);
    logic              req;
    logic              lock;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin select.
//   req0, req1 : requests
//   prio       : 0 = port 0 wins a tie, 1 = port 1 wins a tie
//   gnt        : one-hot grant {port1, port0}, zero when nobody requests
module dmem_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && (!req1 || !prio)) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the CPU load/store path
// (p0) and the debug/DMA loader (p1). One access per cycle, round-robin on
// ties, with a bounded lock for read-modify-write bursts.
//   clk, rst_n       : clock, asynchronous active-low reset
//   p0, p1           : requester ports (dmem_arbiter_if.slave)
//   mem_addr/we/re/wdata : memory pins, driven from the winner, zero when idle
//   mem_rdata        : combinational memory read data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no lock held; winner chosen round-robin
// OWN0  | port 0 holds the lock; wins while req0 && lock0
// OWN1  | port 1 holds the lock; wins while req1 && lock1
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX - 1);

    owner_t            owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]        rr_gnt;
    logic [1:0]        win;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    dmem_rr_pick u_pick (
        .req0 (p0.req),
        .req1 (p1.req),
        .prio (prio_q),
        .gnt  (rr_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        owner_d = IDLE;
        cnt_d   = '0;
        win     = rr_gnt;
        // Saturates so an uncontested lock can be held indefinitely.
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        if (owner_q == OWN0 && p0.req && p0.lock) begin
            win = 2'b01;
            // cnt_inc counts grants after the entry grant, so reaching
            // CNT_MAX means LOCK_MAX grants have gone to this port.
            if (!(p1.req && cnt_inc >= CNT_MAX)) begin
                owner_d = OWN0;
                cnt_d   = cnt_inc;
            end
        end else if (owner_q == OWN1 && p1.req && p1.lock) begin
            win = 2'b10;
            if (!(p0.req && cnt_inc >= CNT_MAX)) begin
                owner_d = OWN1;
                cnt_d   = cnt_inc;
            end
        end else if (rr_gnt[0] && p0.lock && (LOCK_MAX > 1 || !p1.req)) begin
            owner_d = OWN0;
        end else if (rr_gnt[1] && p1.lock && (LOCK_MAX > 1 || !p0.req)) begin
            owner_d = OWN1;
        end

        // Grants and memory strobes must fall as soon as reset asserts.
        if (!rst_n) begin
            win = 2'b00;
        end

        prio_d = prio_q;
        if (win[0]) begin
            prio_d = 1'b1;
        end else if (win[1]) begin
            prio_d = 1'b0;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (win[0]) begin
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
            mem_we    = p0.we;
            mem_re    = !p0.we;
        end else if (win[1]) begin
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
            mem_we    = p1.we;
            mem_re    = !p1.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q[0] <= win[0] && !p0.we;
            rvalid_q[1] <= win[1] && !p1.we;
            if (win[0] && !p0.we) begin
                rdata0_q <= mem_rdata;
            end
            if (win[1] && !p1.we) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign p0.gnt    = win[0];
    assign p1.gnt    = win[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues accesses and pushes the
// expected grant / read-data into queues from a behavioural model; a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_dmem_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 4;

    typedef struct {
        int          due;
        int          port;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } g_exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory the arbiter talks to (environment, not the reference model).
    logic [DW-1:0] mem [32];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [32];
    int m_pref;     // port that wins a tie
    int m_holder;   // port holding the lock, -1 when none
    int m_run;      // grants given to the holder in the current burst

    task automatic model_reset();
        m_pref = 0;
        m_holder = -1;
        m_run = 0;
    endtask

    task automatic model_step(input bit [1:0] r, input bit [1:0] l, output int w);
        w = -1;
        if (m_holder >= 0 && r[m_holder] && l[m_holder]) begin
            w = m_holder;
            m_run++;
            if (r[1 - w] && m_run >= LOCK_MAX) m_holder = -1;
        end else begin
            if (r[0] && r[1]) w = m_pref;
            else if (r[0]) w = 0;
            else if (r[1]) w = 1;
            m_holder = -1;
            if (w >= 0 && l[w]) begin
                m_holder = w;
                m_run = 1;
            end
        end
        if (w >= 0) m_pref = 1 - w;
    endtask

    g_exp_t gq[$];
    r_exp_t rq[2][$];
    int     gnt_log[$];

    // ---------------- driver ----------------
    task automatic drive(input bit [1:0] r, input bit [1:0] l, input bit [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         output int w);
        g_exp_t e;
        r_exp_t x;
        p0_if.req = r[0]; p0_if.lock = l[0]; p0_if.we = we[0]; p0_if.addr = a0; p0_if.wdata = d0;
        p1_if.req = r[1]; p1_if.lock = l[1]; p1_if.we = we[1]; p1_if.addr = a1; p1_if.wdata = d1;
        model_step(r, l, w);
        if (w >= 0) begin
            e.due = cyc; e.port = w; e.we = we[w];
            e.addr = (w == 1) ? a1 : a0;
            e.wdata = (w == 1) ? d1 : d0;
            gq.push_back(e);
            if (e.we) begin
                m_mem[e.addr] = e.wdata;
            end else begin
                x.due = cyc + 1;
                x.data = m_mem[e.addr];
                rq[w].push_back(x);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        int gp;
        g_exp_t e;
        r_exp_t x;
        logic rv;
        logic [DW-1:0] rd;
        if (rst_n) begin
            gp = p0_if.gnt ? 0 : (p1_if.gnt ? 1 : -1);
            gnt_log.push_back(gp);
            chk("gnt_exclusive", int'(p0_if.gnt && p1_if.gnt), 0);
            chk("we_re_exclusive", int'(mem_we && mem_re), 0);
            if (gq.size() != 0 && gq[0].due <= cyc) begin
                e = gq.pop_front();
                chk("gnt_port", gp, e.port);
                chk("mem_we", int'(mem_we), int'(e.we));
                chk("mem_re", int'(mem_re), int'(!e.we));
                chk("mem_addr", int'(mem_addr), int'(e.addr));
                chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
            end else begin
                chk("gnt_idle", gp, -1);
                chk("idle_bus", int'({mem_we, mem_re, mem_addr, mem_wdata}), 0);
            end
            for (int p = 0; p < 2; p++) begin
                rv = (p == 1) ? p1_if.rvalid : p0_if.rvalid;
                rd = (p == 1) ? p1_if.rdata : p0_if.rdata;
                if (rq[p].size() != 0 && rq[p][0].due <= cyc) begin
                    x = rq[p].pop_front();
                    chk($sformatf("rvalid%0d", p), int'(rv), 1);
                    if (rv) chk($sformatf("rdata%0d", p), int'(rd), int'(x.data));
                end else begin
                    chk($sformatf("rvalid%0d_idle", p), int'(rv), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int w, s, first, n0;
        int pat [6];
        bit [1:0] r, lk, we;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];

        for (int i = 0; i < 32; i++) begin
            mem[i] = DW'(i * 37 + 11);
            m_mem[i] = DW'(i * 37 + 11);
        end
        mem[3] = 8'hA5;
        m_mem[3] = 8'hA5;
        model_reset();

        // Requests asserted during reset must not produce grants.
        p0_if.req = 1; p0_if.lock = 1; p0_if.we = 0; p0_if.addr = 3; p0_if.wdata = 0;
        p1_if.req = 1; p1_if.lock = 0; p1_if.we = 1; p1_if.addr = 4; p1_if.wdata = 8'h55;
        #22;
        chk("rst_gnt0", int'(p0_if.gnt), 0);
        chk("rst_gnt1", int'(p1_if.gnt), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_re", int'(mem_re), 0);
        chk("rst_rvalid", int'({p0_if.rvalid, p1_if.rvalid}), 0);
        chk("rst_rdata0", int'(p0_if.rdata), 0);
        chk("rst_rdata1", int'(p1_if.rdata), 0);
        p0_if.req = 0; p1_if.req = 0; p0_if.lock = 0;
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // Single read of the preloaded location.
        drive(2'b01, 2'b00, 2'b00, 5'd3, 5'd0, 8'h00, 8'h00, w);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);

        // Write by port 1 then read of the same address by port 0.
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd7, 8'h00, 8'h3C, w);
        drive(2'b01, 2'b00, 2'b00, 5'd7, 5'd0, 8'h00, 8'h00, w);
        // Lone port-1 access leaves port 0 preferred for the lock test.
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd1, 8'h00, 8'h00, w);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);

        // Lock bound under contention.
        pat = '{0, 0, 0, 0, 1, 0};
        s = gnt_log.size();
        for (int k = 0; k < 6; k++)
            drive(2'b11, 2'b01, 2'b00, AW'(k), AW'(k + 8), 8'h00, 8'h00, w);
        for (int k = 0; k < 6; k++)
            chk($sformatf("lock_bound_%0d", k), gnt_log[s + k], pat[k]);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);

        // Lock with the other port idle, then the other port starts requesting.
        s = gnt_log.size();
        for (int k = 0; k < 10; k++)
            drive(2'b01, 2'b01, 2'b00, AW'(k), 5'd0, 8'h00, 8'h00, w);
        for (int k = 0; k < 5; k++)
            drive(2'b11, 2'b01, 2'b00, AW'(k), 5'd9, 8'h00, 8'h00, w);
        n0 = 0;
        for (int k = 0; k < 10; k++) if (gnt_log[s + k] == 0) n0++;
        chk("lock_idle_all_gnt0", n0, 10);
        first = -1;
        for (int k = 10; k < 15; k++) if (first < 0 && gnt_log[s + k] == 1) first = k;
        chk("lock_idle_release", int'(first >= 10 && first <= 14), 1);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);

        // Reset in the middle of a locked read burst.
        drive(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 8'h00, 8'h00, w);
        #2;
        chk("pre_rst_gnt0", int'(p0_if.gnt), 1);
        chk("pre_rst_rvalid0", int'(p0_if.rvalid), 1);
        rst_n = 0;
        #1;
        chk("midrst_gnt", int'({p0_if.gnt, p1_if.gnt}), 0);
        chk("midrst_we_re", int'({mem_we, mem_re}), 0);
        chk("midrst_rvalid", int'({p0_if.rvalid, p1_if.rvalid}), 0);
        gq.delete();
        rq[0].delete();
        rq[1].delete();
        model_reset();
        p0_if.req = 0; p0_if.lock = 0; p1_if.req = 0; p1_if.lock = 0;
        @(negedge clk); @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // Plain contention after reset: alternating grants starting at port 0.
        s = gnt_log.size();
        for (int k = 0; k < 4; k++)
            drive(2'b11, 2'b00, 2'b00, AW'(k + 12), AW'(k + 20), 8'h00, 8'h00, w);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_alt_%0d", k), gnt_log[s + k], k % 2);

        // Randomized traffic: requests held until the model grants them.
        r = 0; lk = 0; we = 0;
        a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r[p] && $urandom_range(0, 3) != 0) begin
                    r[p]  = 1'b1;
                    we[p] = 1'($urandom_range(0, 1));
                    a[p]  = AW'($urandom_range(0, 7));
                    d[p]  = DW'($urandom);
                end
                if ($urandom_range(0, 7) == 0) lk[p] = ~lk[p];
            end
            drive(r, lk, we, a[0], a[1], d[0], d[1], w);
            if (w >= 0) r[w] = 1'b0;
        end
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, w);
        chk("queues_drained", gq.size() + rq[0].size() + rq[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32x8 data memory between two requesters:
  - port 0: CPU core load/store path.
  - port 1: debug/DMA loader.
- Grants one access per cycle using round-robin, with an optional bounded lock for read-modify-write sequences.
- Drives the memory's addr / write_enable / read_enable / write_data pins and returns registered read data to the winning requester.

Parameters:
- ADDR_W, 5, memory address width (32 locations).
- DATA_W, 8, data width.
- LOCK_MAX, 4, maximum consecutive locked grants to one port while the other port is requesting.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, level, held until granted.
- lock0, lock1  in  1  with req: keep ownership for following cycles.
- we0, we1  in  1  1 = write, 0 = read; valid with req.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  combinational grant; the access completes this cycle.
- rvalid0, rvalid1  out  1  one-cycle pulse, read data valid.
- rdata0, rdata1  out  DATA_W  registered read data; holds until next read for that port.
- mem_addr  out  ADDR_W  to memory address.
- mem_we  out  1  to memory write_enable.
- mem_re  out  1  to memory read_enable.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory read_data (combinational).

Behaviour:
- Reset (async assert, sync release) values:
  - rdata0/1 = 0; rvalid0/1 = 0.
  - prio pointer = port 0; owner = NONE; lock_cnt = 0.
  - gnt0/1, mem_we, mem_re = 0 combinationally while rst_n low.
- FSM, state = owner, one of IDLE, OWN0, OWN1:
  - IDLE/no lock: winner is the requesting port; if both request, the port indicated by prio wins. After a grant, prio points to the other port.
  - Granted with lockN=1 → next state OWNn.
  - In OWNn:
    - port n wins unconditionally while reqN && lockN; lock_cnt increments on each locked grant.
    - Exit to IDLE when port n drops req or lock.
    - Also exit when lock_cnt reaches LOCK_MAX-1 and the other port is requesting; the other port is then granted next cycle.
  - lock_cnt clears on leaving OWNn.
  - While the other port is idle, the lock has no limit and lock_cnt saturates.
- Grant cycle N:
  - gntN=1.
  - mem_addr/mem_wdata muxed from winner.
  - mem_we = weN; mem_re = ~weN.
  - With no grant: mem_we = mem_re = 0, and mem_addr/mem_wdata = 0.
- Read latency:
  - mem_rdata captured into rdataN at the end of cycle N.
  - rvalidN = 1 in cycle N+1 only.
- Write takes effect at the edge ending cycle N. A read of the same address in N+1 returns the new data.
- Back-to-back grants to either port are allowed every cycle; throughput is 1 access/cycle.
- A requester not granted sees gnt=0 and must hold req/we/addr/wdata stable.
- Never both gnt0 and gnt1 in one cycle; mem_we and mem_re are mutually exclusive.
- lockN without reqN is ignored.
- Reset mid-lock: owner returns to IDLE; a pending rvalid is dropped (not issued after release).

Decomposition:
- Package dmem_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - owner_t enum {IDLE, OWN0, OWN1}.
  - LOCK_MAX default.
- Sub-module dmem_rr_pick:
  - Function: combinational 2-way round-robin select.
  - Inputs: req0, req1, prio.
  - Outputs: one-hot grant.
  - Used by the top when owner=IDLE.
- Read-data registers and lock FSM stay in the top.

Test Plan:
- Reset then single read: mem[3]=8'hA5 preloaded; req0, we0=0, addr0=3 → gnt0 in cycle 0; rvalid0=1, rdata0=8'hA5 in cycle 1; rvalid1 stays 0.
- Simultaneous requests, no lock: req0 and req1 held 4 cycles → grants alternate 0,1,0,1 (prio starts at 0); each port sees 2 grants.
- Write-then-read forwarding: port1 writes 8'h3C to addr 7 in cycle N; port0 reads addr 7 in N+1 → rdata0=8'h3C, rvalid0 in N+2.
- Lock bound: port0 req+lock continuous, port1 req continuous, LOCK_MAX=4 → gnt0 exactly 4 consecutive cycles, then gnt1 in cycle 5, then port0 again.
- Lock, other idle: port0 locked for 10 cycles with req1=0 → gnt0 all 10 cycles. req1 rises at cycle 10 → gnt1 no later than 4 cycles after.
- Async reset mid-operation: rst_n low during a locked read cycle → gnt0/1, mem_we, mem_re, rvalid0/1 drop immediately. After release, the first simultaneous request grants port 0.
